// File: rtl/knightrider_pkg.sv
// Shared types and constants for the knight-rider sequencing controller.
package knightrider_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int LED_W   = 10;
  localparam int IDX_MAX = 9;

endpackage

// File: rtl/debounce.sv
// Button debouncer: the accepted level follows the input only after it has
// held a new value for DEBOUNCE consecutive cycles; rise marks a 0->1 acceptance.
module debounce #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic CLK,
  input  logic CLEAR,
  input  logic in,
  output logic out,
  output logic rise
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          accept;

  assign accept = (in != lvl_q) && (cnt_q == CW'(DEBOUNCE - 1));

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (in != lvl_q) begin
      if (accept) lvl_d = in;
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  // rise coincides with the edge that updates the level, so a request can be
  // latched downstream without an extra cycle of delay.
  assign out  = lvl_q;
  assign rise = accept & in;

endmodule

// File: rtl/knightrider_ctrl.sv
// Knight-rider sequencing controller: generates STEP/UP for the LED counter,
// tracks the expected lit position and flags read-back mismatches.
module knightrider_ctrl
  import knightrider_pkg::*;
#(
  parameter int PRESCALE = 2_500_000,
  parameter int DEBOUNCE = 500_000
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             RUN,
  input  logic [1:0]       SPEED,
  input  logic             REV_BTN,
  input  logic [LED_W-1:0] POS,
  output logic             STEP,
  output logic             UP,
  output logic [3:0]       IDX,
  output logic             ERR
);

  localparam int CNT_W = $clog2(PRESCALE * 8 + 1);

  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] spd);
    return CNT_W'(PRESCALE) << (2'd3 - spd);
  endfunction

  logic             run_s1_q, run_s2_q;
  logic [1:0]       spd_s1_q, spd_s2_q;
  logic             rev_s1_q, rev_s2_q;
  logic [LED_W-1:0] pos_s1_q, pos_s2_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             step_q, step_d;
  logic [3:0]       idx_q, idx_d;
  dir_t             state_q, state_d;
  logic             rev_q, rev_d;
  logic             err_q, err_d;

  logic             tc;
  logic             chk_now;
  logic             rev_lvl, rev_rise;

  // ---- input synchronisers ----
  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      spd_s1_q <= 2'd0;
      spd_s2_q <= 2'd0;
      rev_s1_q <= 1'b0;
      rev_s2_q <= 1'b0;
      pos_s1_q <= '0;
      pos_s2_q <= '0;
    end else begin
      run_s1_q <= RUN;
      run_s2_q <= run_s1_q;
      spd_s1_q <= SPEED;
      spd_s2_q <= spd_s1_q;
      rev_s1_q <= REV_BTN;
      rev_s2_q <= rev_s1_q;
      pos_s1_q <= POS;
      pos_s2_q <= pos_s1_q;
    end
  end

  debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_rev_db (
    .CLK  (CLK),
    .CLEAR(CLEAR),
    .in   (rev_s2_q),
    .out  (rev_lvl),
    .rise (rev_rise)
  );

  // ---- prescaler, position and checker ----
  assign tc      = run_s2_q && (cnt_q == '0);
  assign chk_now = (cnt_q == period_q - CNT_W'(4));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    idx_d    = idx_q;
    step_d   = tc;
    if (run_s2_q) begin
      if (tc) begin
        period_d = period_of(spd_s2_q);
        cnt_d    = period_of(spd_s2_q) - CNT_W'(1);
        idx_d    = (state_q == DIR_LEFT) ? idx_q + 4'd1 : idx_q - 4'd1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    err_d = err_q | (chk_now && (pos_s2_q != (LED_W'(1) << idx_q)));
    // A request landing on the consuming cycle survives for the next step.
    rev_d = (rev_q & ~step_q) | (rev_rise & ~rev_lvl);
  end

  // ---- direction FSM: evaluated one cycle after the step, on the new IDX ----
  always_comb begin
    state_d = state_q;
    if (step_q) begin
      if (idx_q == 4'(IDX_MAX))  state_d = DIR_RIGHT;
      else if (idx_q == 4'd0)    state_d = DIR_LEFT;
      else if (rev_q)            state_d = (state_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      cnt_q    <= period_of(2'd0) - CNT_W'(1);
      period_q <= period_of(2'd0);
      step_q   <= 1'b0;
      idx_q    <= 4'd0;
      state_q  <= DIR_LEFT;
      rev_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      rev_q    <= rev_d;
      err_q    <= err_d;
    end
  end

  assign STEP = step_q;
  assign UP   = state_q;
  assign IDX  = idx_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_knightrider_ctrl.sv
// Randomised bench for knightrider_ctrl with an attached LED counter and a
// behavioural sweep model.
module tb_knightrider_ctrl;

  localparam int PRE = 4;
  localparam int DEB = 3;

  logic       CLK = 1'b0;
  logic       CLEAR;
  logic       RUN;
  logic [1:0] SPEED;
  logic       REV_BTN;
  logic [9:0] POS;
  logic       STEP;
  logic       UP;
  logic [3:0] IDX;
  logic       ERR;

  knightrider_ctrl #(
    .PRESCALE(PRE),
    .DEBOUNCE(DEB)
  ) dut (
    .CLK    (CLK),
    .CLEAR  (CLEAR),
    .RUN    (RUN),
    .SPEED  (SPEED),
    .REV_BTN(REV_BTN),
    .POS    (POS),
    .STEP   (STEP),
    .UP     (UP),
    .IDX    (IDX),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Input histories: *_h1 is what the design sees after its two-flop sync.
  bit       run_h0, run_h1, rev_h0, rev_h1;
  bit [1:0] spd_h0, spd_h1;
  bit [9:0] pos_h0, pos_h1;

  int m_el;     // active cycles elapsed in the current period
  int m_per;    // current period length
  int m_pos;
  bit m_dir;    // 0 = toward bit 9
  bit m_pend;
  bit m_step;
  bit m_err;
  bit m_acc;    // accepted button level
  bit rq[$];    // recent synchronised button samples

  logic [9:0] cnt_pos;
  bit         fault;
  bit         clr_seen;

  task automatic model_edge();
    bit run_s, rev_s, nstep, same;
    bit [1:0] spd_s;
    bit [9:0] pos_s;
    if (!CLEAR) begin
      run_h0 = 0; run_h1 = 0; rev_h0 = 0; rev_h1 = 0;
      spd_h0 = 0; spd_h1 = 0; pos_h0 = 0; pos_h1 = 0;
      m_el = 0; m_per = 8 * PRE; m_pos = 0; m_dir = 0;
      m_pend = 0; m_step = 0; m_err = 0; m_acc = 0;
      rq.delete();
      return;
    end
    run_s = run_h1; rev_s = rev_h1; spd_s = spd_h1; pos_s = pos_h1;

    // Read-back is compared three active cycles into each period.
    if (m_el == 3 && pos_s != (10'd1 << m_pos)) m_err = 1;

    nstep = run_s && (m_el == m_per - 1);

    if (m_step) begin
      if (m_pos == 9)      m_dir = 1;
      else if (m_pos == 0) m_dir = 0;
      else if (m_pend)     m_dir = !m_dir;
      m_pend = 0;
    end

    rq.push_back(rev_s);
    if (rq.size() > DEB) void'(rq.pop_front());
    if (rq.size() == DEB) begin
      same = 1;
      foreach (rq[i]) if (rq[i] != rev_s) same = 0;
      if (same && rev_s != m_acc) begin
        m_acc = rev_s;
        if (rev_s) m_pend = 1;
      end
    end

    if (nstep) m_pos = m_dir ? m_pos - 1 : m_pos + 1;
    if (run_s) begin
      if (nstep) begin
        m_el  = 0;
        m_per = PRE << (3 - spd_s);
      end else begin
        m_el++;
      end
    end
    m_step = nstep;

    run_h1 = run_h0; run_h0 = RUN;
    rev_h1 = rev_h0; rev_h0 = REV_BTN;
    spd_h1 = spd_h0; spd_h0 = SPEED;
    pos_h1 = pos_h0; pos_h0 = POS;
  endtask

  task automatic cycle();
    @(posedge CLK);
    clr_seen = !CLEAR;
    model_edge();
    @(negedge CLK);
    if (clr_seen)  cnt_pos = 10'd1;
    else if (STEP) cnt_pos = UP ? (cnt_pos >> 1) : (cnt_pos << 1);
    POS = fault ? 10'b0000000100 : cnt_pos;
    chk("step", STEP, m_step);
    chk("up",   UP,   m_dir);
    chk("idx",  IDX,  m_pos);
    chk("err",  ERR,  m_err);
  endtask

  initial begin
    CLEAR = 1'b0; RUN = 1'b0; SPEED = 2'd0; REV_BTN = 1'b0;
    cnt_pos = 10'd1; POS = 10'd1; fault = 0;

    repeat (2) cycle();
    chk("rst_idx",  IDX,  0);
    chk("rst_up",   UP,   0);
    chk("rst_step", STEP, 0);
    chk("rst_err",  ERR,  0);

    // Free sweep at the fastest speed.
    CLEAR = 1'b1; RUN = 1'b1; SPEED = 2'd3;
    repeat (200) cycle();
    chk("sweep_err", ERR, 0);

    // Speed change mid-period, then a hold.
    repeat (2) cycle();
    SPEED = 2'd0;
    repeat (100) cycle();
    RUN = 1'b0;
    repeat (50) cycle();
    RUN = 1'b1; SPEED = 2'd3;
    repeat (40) cycle();

    // Bounce made of 2-cycle pulses.
    for (int k = 0; k < 6; k++) begin
      REV_BTN = 1'b1; repeat (2) cycle();
      REV_BTN = 1'b0; repeat (2) cycle();
    end

    // Clean presses at random points of the sweep.
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(5, 40)) cycle();
      REV_BTN = 1'b1; repeat ($urandom_range(4, 10)) cycle();
      REV_BTN = 1'b0; repeat (4) cycle();
    end

    // Corrupted read-back near IDX=1, then clear.
    for (int g = 0; g < 200 && m_pos != 1; g++) cycle();
    fault = 1;
    repeat (8) cycle();
    fault = 0;
    repeat (20) cycle();
    CLEAR = 1'b0; cycle(); CLEAR = 1'b1;
    repeat (30) cycle();

    // Random soak.
    for (int c = 0; c < 5000; c++) begin
      if (RUN && $urandom_range(0, 199) == 0) RUN = 1'b0;
      else if (!RUN && $urandom_range(0, 19) == 0) RUN = 1'b1;
      if ($urandom_range(0, 149) == 0) SPEED = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) REV_BTN = ~REV_BTN;
      if ($urandom_range(0, 299) == 0) fault = ~fault;
      CLEAR = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/knightrider_ctrl.md
# knightrider_ctrl

Sequencing controller that drives the knight-rider up/down counter from the input side. It generates the counter's step clock (STEP) and direction (UP) so the lit LED sweeps 0→9→0 continuously. It accepts a run switch, a speed select and a reverse push-button. It reads the counter's 10-bit one-hot LED bus back and flags any mismatch with its internal position model. It sits between board switches/buttons and the counter in the top level.

## Interface
- PRESCALE, default 2_500_000: base step period in CLK cycles; must be ≥ 4.
- DEBOUNCE, default 500_000: number of CLK cycles REV_BTN must be stable before it is accepted.
- CLK  in  1  system clock; all logic is on the rising edge.
- CLEAR  in  1  reset. One clock; reset is synchronous and active-low.
- RUN  in  1  asynchronous switch; 1 = sweep, 0 = hold position.
- SPEED  in  2  asynchronous switch; step period = PRESCALE << (3 − SPEED), so 3 is fastest.
- REV_BTN  in  1  raw active-high push-button; a debounced press reverses direction.
- POS  in  10  one-hot LED bus from the counter; asynchronous to the STEP edge.
- STEP  out  1  registered one-CLK-wide pulse; clocks the counter.
- UP  out  1  counter direction; 0 = move toward bit 9, 1 = move toward bit 0.
- IDX  out  4  model position, 0..9.
- ERR  out  1  sticky mismatch flag.

## Operation
- Synchronise RUN, SPEED, REV_BTN and POS through 2 flops each before use.
- Prescaler:
  - Down-counter, reloaded with period−1; SPEED is sampled only at reload.
  - At terminal count with RUN=1, STEP=1 for exactly one cycle.
  - With RUN=0, the prescaler holds its value and no STEP is issued.
- Direction FSM has two states: LEFT (UP=0) and RIGHT (UP=1).
- At each STEP cycle (edge E):
  - IDX ← IDX+1 in LEFT, IDX−1 in RIGHT.
  - Next-state is computed from the new IDX: IDX=9 → RIGHT; IDX=0 → LEFT; otherwise stay, or toggle if a reverse request is pending.
- Reverse request:
  - Set by a debounced 0→1 edge of REV_BTN.
  - Cleared when consumed at the next STEP.
  - Ignored (but still cleared) when the new IDX is 0 or 9, because the end forces direction.
  - A second press before the next STEP has no further effect.
- Debounce: a counter restarts on any change of the synchronised REV_BTN. The accepted level updates after DEBOUNCE stable cycles.
- Checker:
  - At prescaler value period−4 (3 cycles after E, past sync latency), compare the synchronised POS with 1<<IDX.
  - On mismatch, set ERR = 1; ERR clears only on reset.
- Reset (CLEAR=0 at a rising edge), which also applies mid-sweep:
  - IDX=0, state LEFT, UP=0, STEP=0, ERR=0.
  - Prescaler is loaded with the reload value for SPEED=0; pending reverse and debounce state are cleared.
  - The counter resets on the same CLEAR, so the model and the counter realign.

## Timing
- STEP rises at edge E and falls at E+1.
- UP must not change at E; it takes the new FSM state at E+1. It is therefore stable ≥ (period−1) cycles before the next STEP rise.
- IDX updates at E.
- Input latency: RUN/SPEED take 2 cycles, plus up to one period for SPEED.
- REV_BTN latency: 2 + DEBOUNCE cycles until the request is set.
- ERR asserts 4 cycles after E at the earliest.
- Sweep cycle: 18 STEPs per full 0→9→0 round trip; ends are not repeated.

## Structure
- Shared package knightrider_pkg holds:
  - typedef dir_t (DIR_LEFT=0, DIR_RIGHT=1);
  - constants LED_W=10 and IDX_MAX=9.
- Sub-module debounce (parameter DEBOUNCE; ports CLK, CLEAR, in, out, rise) is natural and reusable for other buttons.
- Everything else (prescaler, FSM, checker) lives in one module.

## Test plan
- PRESCALE=4, SPEED=3, RUN=1 after reset; bench counter model attached:
  - STEP every 4 cycles;
  - IDX sequence 1..9,8..0,1;
  - UP goes 0→1 at the E+1 after IDX=9, and 1→0 at the E+1 after IDX=0;
  - ERR stays 0.
- SPEED changed 3→0 mid-period: current period completes at 4 cycles, next period is 32; RUN=0 for 50 cycles gives no STEP and IDX/prescaler hold.
- DEBOUNCE=3:
  - a REV_BTN bounce of 2-cycle pulses is rejected;
  - a clean press at IDX=4 in LEFT gives next IDX 5 and UP=1 at E+1, then 4, 3, …;
  - a press landing at IDX=8 in LEFT is dropped: next IDX 9, then RIGHT.
- Fault injection: force POS=10'b0000000100 while IDX=1 → ERR=1 at E+4 and stays 1 until CLEAR.
- CLEAR=0 for one cycle mid-sweep at IDX=6 in RIGHT → next cycle IDX=0, UP=0, STEP=0, ERR=0; sweep resumes 1, 2, ….
